// File: rtl/apb4_rr_master.sv
// apb4_rr_master
//
// Round-robin APB4 master shared by two user-side requesters. One transfer
// is sequenced at a time through IDLE -> SETUP -> ACCESS. Completion, read
// data and error status are returned to the granted requester as a single
// cycle pulse. A wait-state watchdog aborts a transfer whose slave never
// asserts PREADY.
//
// Ports
//   PCLK, PRESET                clock, synchronous active-high reset
//   REQ_i, WRITE_i, ADDR_i,     requester i transfer request and fields,
//   WDATA_i, STRB_i             held stable until DONE_i
//   DONE_i, RDATA_i, SLVERR_i   requester i completion pulse, read data, error
//   PSEL, PENABLE, PWRITE,      APB4 request side toward the slave
//   PADDR, PWDATA, PSTRB
//   PREADY, PRDATA, PSLVERR     APB4 response side from the slave
//
// Every output is a register; the combinational process only computes the
// next value of each register.

module apb4_rr_master #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int TIMEOUT    = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,

  input  logic                  REQ_0,
  input  logic                  WRITE_0,
  input  logic [ADDR_WIDTH-1:0] ADDR_0,
  input  logic [DATA_WIDTH-1:0] WDATA_0,
  input  logic [STRB_WIDTH-1:0] STRB_0,
  output logic                  DONE_0,
  output logic [DATA_WIDTH-1:0] RDATA_0,
  output logic                  SLVERR_0,

  input  logic                  REQ_1,
  input  logic                  WRITE_1,
  input  logic [ADDR_WIDTH-1:0] ADDR_1,
  input  logic [DATA_WIDTH-1:0] WDATA_1,
  input  logic [STRB_WIDTH-1:0] STRB_1,
  output logic                  DONE_1,
  output logic [DATA_WIDTH-1:0] RDATA_1,
  output logic                  SLVERR_1,

  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             last, last_nxt;
  logic             gnt, gnt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic                  psel_nxt;
  logic                  penable_nxt;
  logic                  pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic [STRB_WIDTH-1:0] pstrb_nxt;

  logic                  done0_nxt, done1_nxt;
  logic [DATA_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
  logic                  slverr0_nxt, slverr1_nxt;

  logic                  finish;
  logic [DATA_WIDTH-1:0] fin_rdata;
  logic                  fin_slverr;

  // A requester whose DONE is high this cycle still holds REQ for the
  // transfer just completed, so it must not be granted again here.
  logic elig0, elig1, pick;
  assign elig0 = REQ_0 & ~DONE_0;
  assign elig1 = REQ_1 & ~DONE_1;
  // On a tie the requester not served last wins.
  assign pick  = (elig0 & elig1) ? ~last : elig1;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;
  assign sel_write = pick ? WRITE_1 : WRITE_0;
  assign sel_addr  = pick ? ADDR_1  : ADDR_0;
  assign sel_wdata = pick ? WDATA_1 : WDATA_0;
  assign sel_strb  = pick ? STRB_1  : STRB_0;

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    gnt_nxt     = gnt;
    cnt_nxt     = cnt;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    pwrite_nxt  = PWRITE;
    paddr_nxt   = PADDR;
    pwdata_nxt  = PWDATA;
    pstrb_nxt   = PSTRB;
    finish      = 1'b0;
    fin_rdata   = '0;
    fin_slverr  = 1'b0;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    rdata0_nxt  = '0;
    rdata1_nxt  = '0;
    slverr0_nxt = 1'b0;
    slverr1_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_nxt    = pick;
          psel_nxt   = 1'b1;
          pwrite_nxt = sel_write;
          paddr_nxt  = sel_addr;
          pwdata_nxt = sel_write ? sel_wdata : '0;
          pstrb_nxt  = sel_write ? sel_strb  : '0;
          state_nxt  = SETUP;
        end
      end

      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          finish     = 1'b1;
          fin_rdata  = PWRITE ? '0 : PRDATA;
          fin_slverr = PSLVERR;
        end else if (cnt == CNT_MAX) begin
          // Watchdog abort: reported as an error with no read data.
          finish     = 1'b1;
          fin_rdata  = '0;
          fin_slverr = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end

        if (finish) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          last_nxt    = gnt;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase

    if (finish) begin
      if (gnt) begin
        done1_nxt   = 1'b1;
        rdata1_nxt  = fin_rdata;
        slverr1_nxt = fin_slverr;
      end else begin
        done0_nxt   = 1'b1;
        rdata0_nxt  = fin_rdata;
        slverr0_nxt = fin_slverr;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      DONE_0   <= 1'b0;
      RDATA_0  <= '0;
      SLVERR_0 <= 1'b0;
      DONE_1   <= 1'b0;
      RDATA_1  <= '0;
      SLVERR_1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      cnt      <= cnt_nxt;
      PSEL     <= psel_nxt;
      PENABLE  <= penable_nxt;
      PWRITE   <= pwrite_nxt;
      PADDR    <= paddr_nxt;
      PWDATA   <= pwdata_nxt;
      PSTRB    <= pstrb_nxt;
      DONE_0   <= done0_nxt;
      RDATA_0  <= rdata0_nxt;
      SLVERR_0 <= slverr0_nxt;
      DONE_1   <= done1_nxt;
      RDATA_1  <= rdata1_nxt;
      SLVERR_1 <= slverr1_nxt;
    end
  end

endmodule

// File: tb/tb_apb4_rr_master.sv
// tb_apb4_rr_master
//
// Directed bench for apb4_rr_master built with TIMEOUT=4. Inputs are driven
// 1 time unit after each rising edge and the registered outputs are compared
// at the same point against hand-computed values.

module tb_apb4_rr_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          PCLK;
  logic          PRESET;
  logic          REQ_0, WRITE_0, REQ_1, WRITE_1;
  logic [AW-1:0] ADDR_0, ADDR_1;
  logic [DW-1:0] WDATA_0, WDATA_1;
  logic [SW-1:0] STRB_0, STRB_1;
  logic          DONE_0, SLVERR_0, DONE_1, SLVERR_1;
  logic [DW-1:0] RDATA_0, RDATA_1;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;

  int checkCount = 0;
  int passCount  = 0;

  apb4_rr_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .REQ_0   (REQ_0),
    .WRITE_0 (WRITE_0),
    .ADDR_0  (ADDR_0),
    .WDATA_0 (WDATA_0),
    .STRB_0  (STRB_0),
    .DONE_0  (DONE_0),
    .RDATA_0 (RDATA_0),
    .SLVERR_0(SLVERR_0),
    .REQ_1   (REQ_1),
    .WRITE_1 (WRITE_1),
    .ADDR_1  (ADDR_1),
    .WDATA_1 (WDATA_1),
    .STRB_1  (STRB_1),
    .DONE_1  (DONE_1),
    .RDATA_1 (RDATA_1),
    .SLVERR_1(SLVERR_1),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit idx, input logic req, input logic write,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb);
    if (idx == 1'b0) begin
      REQ_0 = req; WRITE_0 = write; ADDR_0 = addr; WDATA_0 = wdata; STRB_0 = strb;
    end else begin
      REQ_1 = req; WRITE_1 = write; ADDR_1 = addr; WDATA_1 = wdata; STRB_1 = strb;
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    logic [AW-1:0] rrAddr [4];
    bit            rrIdx  [4];
    rrAddr[0] = 32'h100; rrIdx[0] = 1'b0;
    rrAddr[1] = 32'h200; rrIdx[1] = 1'b1;
    rrAddr[2] = 32'h100; rrIdx[2] = 1'b0;
    rrAddr[3] = 32'h200; rrIdx[3] = 1'b1;

    PRESET = 1'b1;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);

    // Reset state
    tick(); tick();
    checkOutput("rst_psel",    PSEL,    0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr",   PADDR,   0);
    checkOutput("rst_pwdata",  PWDATA,  0);
    checkOutput("rst_pstrb",   PSTRB,   0);
    checkOutput("rst_done0",   DONE_0,  0);
    checkOutput("rst_done1",   DONE_1,  0);
    PRESET = 1'b0;
    tick();

    // Single write, zero wait states
    $display("[TB] single write");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    PREADY = 1'b1;
    tick();
    checkOutput("wr_setup_psel",    PSEL,    1);
    checkOutput("wr_setup_penable", PENABLE, 0);
    checkOutput("wr_paddr",         PADDR,   32'h10);
    checkOutput("wr_pwrite",        PWRITE,  1);
    checkOutput("wr_pwdata",        PWDATA,  32'hDEADBEEF);
    checkOutput("wr_pstrb",         PSTRB,   4'hF);
    tick();
    checkOutput("wr_access_penable", PENABLE, 1);
    checkOutput("wr_access_done0",   DONE_0,  0);
    tick();
    checkOutput("wr_done0",   DONE_0,   1);
    checkOutput("wr_slverr0", SLVERR_0, 0);
    checkOutput("wr_rdata0",  RDATA_0,  0);
    checkOutput("wr_end_psel", PSEL,    0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checkOutput("wr_done0_drop", DONE_0, 0);
    checkOutput("wr_idle_psel",  PSEL,   0);

    // Read with two wait states from requester 1
    $display("[TB] read with wait states");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'hAAAA5555, 4'hF);
    PREADY = 1'b0;
    tick();
    checkOutput("rd_psel",   PSEL,   1);
    checkOutput("rd_paddr",  PADDR,  32'h20);
    checkOutput("rd_pwrite", PWRITE, 0);
    checkOutput("rd_pstrb",  PSTRB,  0);
    checkOutput("rd_pwdata", PWDATA, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd_wait_penable", PENABLE, 1);
      checkOutput("rd_wait_done1",   DONE_1,  0);
    end
    PREADY = 1'b1; PRDATA = 32'h12345678;
    tick();
    checkOutput("rd_done1",   DONE_1,   1);
    checkOutput("rd_rdata1",  RDATA_1,  32'h12345678);
    checkOutput("rd_slverr1", SLVERR_1, 0);
    checkOutput("rd_done0",   DONE_0,   0);
    checkOutput("rd_end_psel", PSEL,    0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    PRDATA = '0;
    tick();
    checkOutput("rd_done1_drop",  DONE_1,  0);
    checkOutput("rd_rdata1_drop", RDATA_1, 0);
    checkOutput("rd_paddr_hold",  PADDR,   32'h20);

    // Both requesters held continuously: grants alternate 0,1,0,1
    $display("[TB] round robin");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h0000AAAA, 4'h3);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 32'h0000BBBB, 4'hC);
    PREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      checkOutput("rr_psel",  PSEL,  1);
      checkOutput("rr_paddr", PADDR, rrAddr[t]);
      checkOutput("rr_pstrb", PSTRB, rrIdx[t] ? 4'hC : 4'h3);
      tick();
      checkOutput("rr_penable", PENABLE, 1);
      tick();
      checkOutput("rr_done0", DONE_0, rrIdx[t] ? 1'b0 : 1'b1);
      checkOutput("rr_done1", DONE_1, rrIdx[t] ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checkOutput("rr_idle_psel",  PSEL,   0);
    checkOutput("rr_idle_done0", DONE_0, 0);
    checkOutput("rr_idle_done1", DONE_1, 0);

    // Watchdog timeout with TIMEOUT=4
    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h30, '0, '0);
    PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
    tick();
    checkOutput("to_psel", PSEL, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to_access_penable", PENABLE, 1);
      checkOutput("to_access_done0",   DONE_0,  0);
    end
    tick();
    checkOutput("to_done0",   DONE_0,   1);
    checkOutput("to_slverr0", SLVERR_0, 1);
    checkOutput("to_rdata0",  RDATA_0,  0);
    checkOutput("to_psel_end", PSEL,    0);
    checkOutput("to_penable_end", PENABLE, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    PRDATA = '0;
    tick();
    checkOutput("to_slverr0_drop", SLVERR_0, 0);

    // Slave error on a write
    $display("[TB] slave error");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'h01020304, 4'h1);
    PREADY = 1'b1; PSLVERR = 1'b1;
    tick(); tick(); tick();
    checkOutput("se_done0",   DONE_0,   1);
    checkOutput("se_slverr0", SLVERR_0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    PSLVERR = 1'b0;
    tick();
    checkOutput("se_slverr0_drop", SLVERR_0, 0);
    checkOutput("se_done0_drop",   DONE_0,   0);

    // Reset during ACCESS; LAST returns to 1 so requester 0 wins afterwards
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h50, 32'h55555555, 4'hF);
    PREADY = 1'b0;
    tick(); tick();
    checkOutput("rs_access_penable", PENABLE, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h60, 32'h66666666, 4'hF);
    PRESET = 1'b1;
    tick();
    checkOutput("rs_psel",    PSEL,    0);
    checkOutput("rs_penable", PENABLE, 0);
    checkOutput("rs_done0",   DONE_0,  0);
    checkOutput("rs_done1",   DONE_1,  0);
    PRESET = 1'b0; PREADY = 1'b1;
    tick();
    checkOutput("rs_grant_psel",  PSEL,   1);
    checkOutput("rs_grant_paddr", PADDR,  32'h50);
    checkOutput("rs_grant_done0", DONE_0, 0);
    checkOutput("rs_grant_done1", DONE_1, 0);
    tick(); tick();
    checkOutput("rs_done0_after", DONE_0, 1);
    checkOutput("rs_done1_after", DONE_1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checkOutput("rs_next_paddr", PADDR, 32'h60);
    tick(); tick();
    checkOutput("rs_next_done1", DONE_1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
